// File: rtl/pmem_line_adapter.sv
// Cache-line to memory-burst adapter: one 256-bit fill/writeback becomes a BEATS-long burst.
// Optional `PMEM_ADAPTER_STATS_EN adds saturating completed-read/write counters.
module pmem_line_adapter #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pmem_address,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [LINE_W-1:0]  pmem_wdata,
    output logic [LINE_W-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic [31:0]        burst_address,
    output logic               burst_read,
    output logic               burst_write,
    output logic [BURST_W-1:0] burst_wdata,
    input  logic [BURST_W-1:0] burst_rdata,
    input  logic               burst_resp
`ifdef PMEM_ADAPTER_STATS_EN
    ,
    output logic [31:0]        stat_rd_count,
    output logic [31:0]        stat_wr_count
`endif
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
`ifdef PMEM_ADAPTER_STATS_EN
    logic                op_wr_q, op_wr_d;
    logic [31:0]         stat_rd_q, stat_wr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rdata_q <= '0;
`ifdef PMEM_ADAPTER_STATS_EN
            op_wr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rdata_q <= rdata_d;
`ifdef PMEM_ADAPTER_STATS_EN
            op_wr_q <= op_wr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rdata_d = rdata_q;
`ifdef PMEM_ADAPTER_STATS_EN
        op_wr_d = op_wr_q;
`endif
        case (state_q)
            IDLE: begin
                // Writeback has priority so a dirty victim leaves before its replacement arrives.
                if (pmem_write) begin
                    addr_d  = pmem_address & 32'hFFFF_FFE0;
                    wline_d = pmem_wdata;
                    cnt_d   = '0;
                    state_d = WR_BURST;
`ifdef PMEM_ADAPTER_STATS_EN
                    op_wr_d = 1'b1;
`endif
                end else if (pmem_read) begin
                    addr_d  = pmem_address & 32'hFFFF_FFE0;
                    cnt_d   = '0;
                    state_d = RD_BURST;
`ifdef PMEM_ADAPTER_STATS_EN
                    op_wr_d = 1'b0;
`endif
                end
            end
            RD_BURST: begin
                if (burst_resp) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            rdata_d[b*BURST_W +: BURST_W] = burst_rdata;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WR_BURST: begin
                if (burst_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        burst_wdata = '0;
        if (state_q == WR_BURST) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cnt_q == CNT_W'(b)) begin
                    burst_wdata = wline_q[b*BURST_W +: BURST_W];
                end
            end
        end
    end

    assign pmem_rdata    = rdata_q;
    assign pmem_resp     = (state_q == DONE);
    assign burst_read    = (state_q == RD_BURST);
    assign burst_write   = (state_q == WR_BURST);
    assign burst_address = addr_q;

`ifdef PMEM_ADAPTER_STATS_EN
    // Counted on the edge leaving DONE, i.e. once per completed transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else if (state_q == DONE) begin
            if (op_wr_q) begin
                if (stat_wr_q != 32'hFFFF_FFFF) begin
                    stat_wr_q <= stat_wr_q + 32'd1;
                end
            end else begin
                if (stat_rd_q != 32'hFFFF_FFFF) begin
                    stat_rd_q <= stat_rd_q + 32'd1;
                end
            end
        end
    end

    assign stat_rd_count = stat_rd_q;
    assign stat_wr_count = stat_wr_q;
`endif

endmodule

// File: doc/pmem_line_adapter.md
# pmem_line_adapter

Memory-side responder for the cache's 256-bit physical-memory port. Accepts one full-line read (fill) or write (writeback) request from a cache's `pmem_*` interface and carries it out as a 4-beat, 64-bit burst transaction on the DRAM/memory-model side. It returns the assembled line and a single-cycle response to the cache. Sits between each cache (or the arbiter) and main memory.

## Interface
Parameters:
- `LINE_W`, 256, cache line width in bits.
- `BURST_W`, 64, memory beat width; `BEATS = LINE_W/BURST_W` must be a power of two ≥ 2 (default 4).

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous active-high reset
- `pmem_address`  in  32  line address from cache
- `pmem_read`  in  1  line fill request
- `pmem_write`  in  1  line writeback request
- `pmem_wdata`  in  LINE_W  writeback line
- `pmem_rdata`  out  LINE_W  assembled fill line
- `pmem_resp`  out  1  one-cycle completion pulse
- `burst_address`  out  32  line-aligned memory address
- `burst_read`  out  1  memory read burst request
- `burst_write`  out  1  memory write burst request
- `burst_wdata`  out  BURST_W  current write beat
- `burst_rdata`  in  BURST_W  incoming read beat
- `burst_resp`  in  1  beat accepted (write) / beat valid (read)

## Operation
- States: IDLE, RD_BURST, WR_BURST, DONE. Beat counter `cnt` has width log2(BEATS).
- IDLE: on an edge with `pmem_write`=1, latch `pmem_wdata` and address, set `cnt`=0, go to WR_BURST. Otherwise, if `pmem_read`=1, latch the address, set `cnt`=0, go to RD_BURST. Write wins if both are high.
- Latched address is forced line-aligned: `burst_address = {addr[31:5], 5'b0}`. It is held stable for the whole burst.
- RD_BURST: `burst_read`=1. On each edge with `burst_resp`=1, write `burst_rdata` into `pmem_rdata[cnt*BURST_W +: BURST_W]` and increment `cnt`. After the beat with `cnt`=BEATS-1, go to DONE.
- WR_BURST: `burst_write`=1 and `burst_wdata` = latched line slice `[cnt*BURST_W +: BURST_W]`. On each edge with `burst_resp`=1, increment `cnt`. After the last beat, go to DONE.
- Beats need not be consecutive. `burst_resp`=0 stalls the burst with outputs held.
- DONE: `pmem_resp`=1 for exactly one cycle, then go to IDLE. `pmem_read`/`pmem_write` are ignored in DONE.
- `pmem_rdata` is a register. It holds the last completed fill line until the next fill overwrites it; it is undefined mid-fill and valid while `pmem_resp`=1.
- `burst_resp` is ignored in IDLE and DONE.

## Timing
- Reset values: state IDLE, `cnt`=0, `pmem_rdata`=0, `pmem_resp`=0, `burst_read`=0, `burst_write`=0, `burst_address`=0, `burst_wdata`=0.
- Reset mid-burst aborts immediately and returns to IDLE with no `pmem_resp`. The memory side must also be reset.
- Request sampled at edge 0 → `burst_read`/`burst_write` high from cycle 1.
- With back-to-back `burst_resp` on cycles 1..4, the state is DONE in cycle 5 and `pmem_resp` is high in cycle 5. Minimum latency: request-to-resp is BEATS+1 cycles after the sampling edge.
- The cache drops its request on the edge after `pmem_resp`. IDLE is re-entered at cycle 6, so a held-high request is never double-serviced. The earliest new request is accepted on edge 6.
- All outputs are registered or decoded from state only. There is no combinational path from `pmem_*` inputs to `burst_*` outputs.

## Configuration
- `PMEM_ADAPTER_STATS_EN` defined: adds output ports `stat_rd_count` (32) and `stat_wr_count` (32), both reset to 0.
  - Each increments by one on the edge leaving DONE for a read or a write transaction respectively.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Fill: `pmem_read`=1, address 0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - Expect `burst_address`=0x0000_1220.
  - Expect `pmem_resp` high exactly one cycle, 5 cycles after sampling.
  - Expect `pmem_rdata` = {0x44..,0x33..,0x22..,0x11..}.
- Writeback: `pmem_write`=1 with line = 256'h(beat3..beat0), address 0x8000_00FF.
  - Expect `burst_address`=0x8000_00E0.
  - Expect `burst_wdata` sequence beat0, beat1, beat2, beat3, then one `pmem_resp` pulse.
- Stalled read: insert 3 idle cycles (`burst_resp`=0) between beats 1 and 2.
  - Expect `burst_read` held, `burst_address` stable, `pmem_resp` delayed by exactly 3 cycles, and correct line.
- Simultaneous `pmem_read`=`pmem_write`=1 → write burst performed first, `burst_read` never asserted in that transaction.
- Assert `rst` after beat 2 of a read.
  - Expect all outputs 0 immediately, no `pmem_resp`.
  - A subsequent fill completes correctly with `pmem_rdata` fully rewritten.
- With `PMEM_ADAPTER_STATS_EN`: 3 fills + 2 writebacks → `stat_rd_count`=3, `stat_wr_count`=2; `rst` clears both to 0.
